// File: rtl/udma_lsu_pkg.sv
// Shared constants, state encoding and request payload for the UART load/store host.
// Byte streams are LSB first; req_byte() maps a byte index to the outgoing command byte.
package udma_lsu_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;

  localparam int unsigned WR_REQ_BYTES = 9;
  localparam int unsigned RD_REQ_BYTES = 5;
  localparam int unsigned WR_RSP_BYTES = 1;
  localparam int unsigned RD_RSP_BYTES = 4;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_RESP,
    ST_DONE
  } host_state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } host_req_t;

  // Command byte at position idx: opcode, then addr, then wdata (writes only).
  function automatic logic [7:0] req_byte(input host_req_t req, input logic [IDX_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = req.we ? CMD_WRITE : CMD_READ;
      4'd1:    b = req.addr[7:0];
      4'd2:    b = req.addr[15:8];
      4'd3:    b = req.addr[23:16];
      4'd4:    b = req.addr[31:24];
      4'd5:    b = req.wdata[7:0];
      4'd6:    b = req.wdata[15:8];
      4'd7:    b = req.wdata[23:16];
      4'd8:    b = req.wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udma_lsu_host.sv
// Host-side UART load/store initiator: serializes one bus request into command bytes and
// gathers the response. Define UDMA_LSU_HOST_TIMEOUT_EN to bound the response wait.
import udma_lsu_pkg::*;

module udma_lsu_host #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              en_i,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              err_o,
  input  logic              tx_busy_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_data_o,
  input  logic              rx_valid_i,
  input  logic [7:0]        rx_data_i
);

  host_state_e       state;
  logic [IDX_W-1:0]  idx;
  host_req_t         req_q;
  logic [DATA_W-1:0] rbuf;
  logic [DATA_W-1:0] rx_merge;
  logic [IDX_W-1:0]  last_req_idx;
  logic [IDX_W-1:0]  last_rsp_idx;
  logic              tmo_hit;

  assign gnt_o        = (state == ST_IDLE) && en_i && req_i;
  assign last_req_idx = req_q.we ? IDX_W'(WR_REQ_BYTES - 1) : IDX_W'(RD_REQ_BYTES - 1);
  assign last_rsp_idx = req_q.we ? IDX_W'(WR_RSP_BYTES - 1) : IDX_W'(RD_RSP_BYTES - 1);
  assign tx_data_o    = ((state == ST_SEND) || (state == ST_GAP)) ? req_byte(req_q, idx) : 8'h00;

  // Response buffer with the incoming byte placed; writes return a single status byte on top.
  always_comb begin
    rx_merge = rbuf;
    if (req_q.we) begin
      rx_merge = {rx_data_i, 24'h000000};
    end else begin
      case (idx[1:0])
        2'd0: rx_merge[7:0]   = rx_data_i;
        2'd1: rx_merge[15:8]  = rx_data_i;
        2'd2: rx_merge[23:16] = rx_data_i;
        2'd3: rx_merge[31:24] = rx_data_i;
        default: rx_merge = rbuf;
      endcase
    end
  end

`ifdef UDMA_LSU_HOST_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  // Idle time since RESP entry or the last received byte.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tmo_cnt <= 32'd0;
    end else if ((state != ST_RESP) || rx_valid_i) begin
      tmo_cnt <= 32'd0;
    end else begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  assign tmo_hit = (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;

  // TIMEOUT_CYCLES shapes no hardware when the response wait is unbounded.
  if (TIMEOUT_CYCLES == 0) begin : g_tmo_unused
  end
`endif

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state      <= ST_IDLE;
      idx        <= '0;
      req_q      <= '0;
      rbuf       <= '0;
      rdata_o    <= '0;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
      tx_valid_o <= 1'b0;
    end else begin
      tx_valid_o <= 1'b0;
      rvalid_o   <= 1'b0;
      err_o      <= 1'b0;
      if (!en_i) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (gnt_o) begin
              req_q <= '{we: we_i, addr: addr_i, wdata: wdata_i};
              idx   <= '0;
              state <= ST_SEND;
            end
          end
          ST_SEND: begin
            if (!tx_busy_i) begin
              tx_valid_o <= 1'b1;
              state      <= ST_GAP;
            end
          end
          // One dead cycle lets the UART raise busy before it is sampled again.
          ST_GAP: begin
            if (idx == last_req_idx) begin
              idx   <= '0;
              rbuf  <= '0;
              state <= ST_RESP;
            end else begin
              idx   <= idx + 4'd1;
              state <= ST_SEND;
            end
          end
          ST_RESP: begin
            if (rx_valid_i) begin
              rbuf <= rx_merge;
              if (idx == last_rsp_idx) begin
                rdata_o  <= rx_merge;
                rvalid_o <= 1'b1;
                state    <= ST_DONE;
              end else begin
                idx <= idx + 4'd1;
              end
            end else if (tmo_hit) begin
              rdata_o  <= rbuf;
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              state    <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_udma_lsu_host.sv
// Directed bench for udma_lsu_host: TX byte streams, RX assembly, flow control,
// enable drop, ignored RX, async reset and (when built in) the response timeout.
module tb_udma_lsu_host;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        en = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        tx_busy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        gnt, rvalid, err, tx_valid;
  logic [31:0] rdata;
  logic [7:0]  tx_data;

  int total = 0;
  int bad = 0;
  logic [7:0] tx_q[$];
  int busy_len = 2;
  int busy_once = 0;
  int busy_cnt = 0;
  int busy_viol = 0;
  int rv_cnt = 0;

  udma_lsu_host #(.TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rstn_i(rstn), .en_i(en), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid),
    .rdata_o(rdata), .err_o(err), .tx_busy_i(tx_busy), .tx_valid_o(tx_valid),
    .tx_data_o(tx_data), .rx_valid_i(rx_valid), .rx_data_i(rx_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // UART TX model: collects strobed bytes and raises busy after each strobe.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_valid) begin
        tx_q.push_back(tx_data);
        if (tx_busy) busy_viol++;
        busy_cnt  = (busy_once > 0) ? busy_once : busy_len;
        busy_once = 0;
        tx_busy   = (busy_cnt > 0);
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        tx_busy = (busy_cnt > 0);
      end
      if (rvalid) rv_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    we = w; addr = a; wdata = d; req = 1'b1;
    #1;
    n = 0;
    while (n < 20 && !gnt) begin
      @(negedge clk); #1;
      n++;
    end
    chk("gnt", 32'(gnt), 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic wait_tx(input string tag, input int n);
    int i;
    i = 0;
    while (i < 2000 && tx_q.size() < n) begin
      @(negedge clk); #2;
      i++;
    end
    chk(tag, 32'(tx_q.size()), 32'(n));
  endtask

  task automatic check_tx(input string tag, input int n, input logic [71:0] bytes);
    logic [7:0] got;
    wait_tx({tag, "_cnt"}, n);
    for (int i = 0; i < n; i++) begin
      got = (i < tx_q.size()) ? tx_q[i] : 8'hxx;
      chk($sformatf("%s_b%0d", tag, i), 32'(got), 32'(bytes[8*i +: 8]));
    end
    tx_q.delete();
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_rvalid(input string tag, input logic [31:0] exp_d, input logic exp_e,
                             output int lat);
    lat = 0;
    while (lat < 200 && !rvalid) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, "_rdata"}, rdata, exp_d);
    chk({tag, "_err"}, 32'(err), 32'(exp_e));
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_txv", 32'(tx_valid), 32'd0);
    chk("rst_txd", 32'(tx_data), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rstn = 1'b1;
    en = 1'b1;

    // Read with short busy after each byte
    issue(1'b0, 32'h1A2B3C4D, 32'h0);
    check_tx("t1_tx", 5, 72'h1A2B3C4D01);
    send_rx(8'h78); send_rx(8'h56); send_rx(8'h34); send_rx(8'h12);
    wait_rvalid("t1", 32'h12345678, 1'b0, lat);
    chk("t1_lat", 32'(lat), 32'd0);
    @(negedge clk); #1;
    chk("t1_rvcnt", 32'(rv_cnt), 32'd1);

    // Write: 9 bytes out, one status byte back in the top lane
    issue(1'b1, 32'h00000010, 32'hCAFEF00D);
    check_tx("t2_tx", 9, 72'hCAFEF00D0000001000);
    send_rx(8'hA5);
    wait_rvalid("t2", 32'hA5000000, 1'b0, lat);
    @(negedge clk); #1;
    chk("t2_rvcnt", 32'(rv_cnt), 32'd2);

    // Long busy after the first byte
    busy_once = 20;
    issue(1'b0, 32'h55AA00FF, 32'h0);
    check_tx("t3_tx", 5, 72'h55AA00FF01);
    chk("t3_busy_viol", 32'(busy_viol), 32'd0);
    send_rx(8'h11); send_rx(8'h22); send_rx(8'h33); send_rx(8'h44);
    wait_rvalid("t3", 32'h44332211, 1'b0, lat);
    @(negedge clk); #1;
    chk("t3_rvcnt", 32'(rv_cnt), 32'd3);

    // Enable drop mid-response, then a clean transaction
    issue(1'b0, 32'h00000004, 32'h0);
    check_tx("t4a_tx", 5, 72'h0000000401);
    send_rx(8'hAA); send_rx(8'hBB);
    en = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("t4_rvcnt", 32'(rv_cnt), 32'd3);
    chk("t4_rdata_hold", rdata, 32'h44332211);
    chk("t4_no_tx", 32'(tx_q.size()), 32'd0);
    en = 1'b1;
    issue(1'b0, 32'h00000008, 32'h0);
    check_tx("t4b_tx", 5, 72'h0000000801);
    send_rx(8'hDE); send_rx(8'hAD); send_rx(8'hBE); send_rx(8'hEF);
    wait_rvalid("t4b", 32'hEFBEADDE, 1'b0, lat);
    @(negedge clk); #1;
    chk("t4b_rvcnt", 32'(rv_cnt), 32'd4);

    // RX noise while IDLE and while sending
    send_rx(8'h99); send_rx(8'h98);
    #1;
    chk("t5_idle_rdata", rdata, 32'hEFBEADDE);
    chk("t5_idle_rvcnt", 32'(rv_cnt), 32'd4);
    busy_len = 6;
    issue(1'b0, 32'h0000000C, 32'h0);
    send_rx(8'h77); send_rx(8'h76);
    #1;
    chk("t5_send_rdata", rdata, 32'hEFBEADDE);
    check_tx("t5_tx", 5, 72'h0000000C01);
    busy_len = 2;
    send_rx(8'h01); send_rx(8'h02); send_rx(8'h03); send_rx(8'h04);
    wait_rvalid("t5", 32'h04030201, 1'b0, lat);
    @(negedge clk); #1;
    chk("t5_rvcnt", 32'(rv_cnt), 32'd5);

    // Async reset in the middle of a write
    issue(1'b1, 32'h12340000, 32'h0BADBEEF);
    repeat (3) @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    chk("t6_txv", 32'(tx_valid), 32'd0);
    chk("t6_txd", 32'(tx_data), 32'd0);
    chk("t6_rdata", rdata, 32'd0);
    chk("t6_rvalid", 32'(rvalid), 32'd0);
    repeat (2) @(negedge clk);
    busy_cnt = 0; tx_busy = 1'b0;
    tx_q.delete();
    rstn = 1'b1;
    issue(1'b0, 32'h00000020, 32'h0);
    check_tx("t6_tx", 5, 72'h0000002001);
    send_rx(8'h0A); send_rx(8'h0B); send_rx(8'h0C); send_rx(8'h0D);
    wait_rvalid("t6", 32'h0D0C0B0A, 1'b0, lat);
    @(negedge clk); #1;
    chk("t6_rvcnt", 32'(rv_cnt), 32'd6);

    // Response never arrives
    issue(1'b0, 32'h00000030, 32'h0);
    wait_tx("t7_tx_cnt", 5);
    tx_q.delete();
`ifdef UDMA_LSU_HOST_TIMEOUT_EN
    wait_rvalid("t7", 32'h0, 1'b1, lat);
    chk("t7_lat_in_range", 32'((lat >= 16) && (lat <= 18)), 32'd1);
    @(negedge clk); #1;
    chk("t7_rvcnt", 32'(rv_cnt), 32'd7);
`else
    repeat (300) @(negedge clk);
    #1;
    chk("t7_no_rvalid", 32'(rv_cnt), 32'd6);
    chk("t7_err", 32'(err), 32'd0);
    chk("t7_rdata_hold", rdata, 32'h0D0C0B0A);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
